// File: rtl/sd_cmd_arbiter.sv
// N-channel command arbiter for the SPI SD command path.
// Captures per-channel start pulses, grants one owner at a time and holds its fields until done or timeout.
module sd_cmd_arbiter #(
    parameter int NCH     = 2,
    parameter int CMDW    = 6,
    parameter int ARGW    = 32,
    parameter int CRCW    = 7,
    parameter int RR_MODE = 1,
    parameter int TO_CYC  = 65535
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*CMDW-1:0]  req_cmd,
    input  logic [NCH*ARGW-1:0]  req_arg,
    input  logic [NCH*CRCW-1:0]  req_crc,
    input  logic [NCH-1:0]       req_sta,
    input  logic [NCH-1:0]       req_sta40,
    input  logic [NCH-1:0]       req_readit,
    input  logic [NCH-1:0]       req_init,
    input  logic                 done,
    output logic [CMDW-1:0]      cmd,
    output logic [ARGW-1:0]      arg,
    output logic [CRCW-1:0]      crc,
    output logic                 sta,
    output logic                 sta40,
    output logic                 readit,
    output logic                 init,
    output logic [NCH-1:0]       grant,
    output logic                 busy,
    output logic                 timeout
);

    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNTW = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    logic [NCH-1:0]    r_pending;
    logic [NCH-1:0]    r_kind;
    logic [IDXW-1:0]   r_ptr;
    logic [IDXW-1:0]   r_owner;
    logic [CNTW-1:0]   r_cnt;
    logic [CMDW-1:0]   r_cmd;
    logic [ARGW-1:0]   r_arg;
    logic [CRCW-1:0]   r_crc;
    logic              r_sta;
    logic              r_sta40;
    logic              r_readit;
    logic              r_init;
    logic [NCH-1:0]    r_grant;
    logic              r_timeout;

    state_t            w_stateNext;
    logic [NCH-1:0]    w_pulse;
    logic [NCH-1:0]    w_pendClr;
    logic [NCH-1:0]    w_pendNext;
    logic [NCH-1:0]    w_kindNext;
    logic [IDXW-1:0]   w_ptrNext;
    logic [IDXW-1:0]   w_ownerNext;
    logic [CNTW-1:0]   w_cntNext;
    logic [CMDW-1:0]   w_cmdNext;
    logic [ARGW-1:0]   w_argNext;
    logic [CRCW-1:0]   w_crcNext;
    logic              w_staNext;
    logic              w_sta40Next;
    logic              w_readitNext;
    logic              w_initNext;
    logic [NCH-1:0]    w_grantNext;
    logic              w_timeoutNext;
    logic              w_release;
    logic              w_found;
    logic [IDXW-1:0]   w_winner;
    int                w_scanIdx;

    // A second pulse on an already-pending channel only refreshes its kind; sta40 wins a tie.
    assign w_pulse    = req_sta | req_sta40;
    assign w_pendNext = (r_pending & ~w_pendClr) | w_pulse;
    assign w_kindNext = (r_kind & ~w_pulse) | req_sta40;

    always_comb begin
        w_found   = 1'b0;
        w_winner  = '0;
        w_scanIdx = 0;
        for (int k = 0; k < NCH; k++) begin
            if (RR_MODE != 0) begin
                w_scanIdx = int'(r_ptr) + k;
                if (w_scanIdx >= NCH) begin
                    w_scanIdx = w_scanIdx - NCH;
                end
            end else begin
                w_scanIdx = k;
            end
            if (!w_found && r_pending[IDXW'(w_scanIdx)]) begin
                w_found  = 1'b1;
                w_winner = IDXW'(w_scanIdx);
            end
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_ownerNext   = r_owner;
        w_ptrNext     = r_ptr;
        w_cntNext     = r_cnt;
        w_cmdNext     = r_cmd;
        w_argNext     = r_arg;
        w_crcNext     = r_crc;
        w_readitNext  = r_readit;
        w_initNext    = r_init;
        w_grantNext   = r_grant;
        w_staNext     = 1'b0;
        w_sta40Next   = 1'b0;
        w_timeoutNext = 1'b0;
        w_pendClr     = '0;
        w_release     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_stateNext         = S_ISSUE;
                    w_ownerNext         = w_winner;
                    w_cmdNext           = req_cmd[w_winner*CMDW +: CMDW];
                    w_argNext           = req_arg[w_winner*ARGW +: ARGW];
                    w_crcNext           = req_crc[w_winner*CRCW +: CRCW];
                    w_readitNext        = req_readit[w_winner];
                    w_initNext          = req_init[w_winner];
                    w_grantNext         = NCH'(1) << w_winner;
                    w_pendClr[w_winner] = 1'b1;
                    w_staNext           = ~r_kind[w_winner];
                    w_sta40Next         = r_kind[w_winner];
                end
            end
            S_ISSUE: begin
                w_stateNext = S_WAIT;
                w_cntNext   = '0;
            end
            S_WAIT: begin
                // done has priority over a timeout expiring in the same cycle
                if (done) begin
                    w_release = 1'b1;
                end else if ((TO_CYC != 0) && (r_cnt == CNTW'(TO_CYC - 1))) begin
                    w_release     = 1'b1;
                    w_timeoutNext = 1'b1;
                end else begin
                    w_cntNext = r_cnt + 1'b1;
                end
                if (w_release) begin
                    w_stateNext  = S_IDLE;
                    w_cntNext    = '0;
                    w_cmdNext    = '0;
                    w_argNext    = '0;
                    w_crcNext    = '0;
                    w_readitNext = 1'b0;
                    w_initNext   = 1'b0;
                    w_grantNext  = '0;
                    if (RR_MODE != 0) begin
                        w_ptrNext = (r_owner == IDXW'(NCH - 1)) ? '0 : r_owner + 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_kind    <= '0;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_cnt     <= '0;
            r_cmd     <= '0;
            r_arg     <= '0;
            r_crc     <= '0;
            r_sta     <= 1'b0;
            r_sta40   <= 1'b0;
            r_readit  <= 1'b0;
            r_init    <= 1'b0;
            r_grant   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_pending <= w_pendNext;
            r_kind    <= w_kindNext;
            r_ptr     <= w_ptrNext;
            r_owner   <= w_ownerNext;
            r_cnt     <= w_cntNext;
            r_cmd     <= w_cmdNext;
            r_arg     <= w_argNext;
            r_crc     <= w_crcNext;
            r_sta     <= w_staNext;
            r_sta40   <= w_sta40Next;
            r_readit  <= w_readitNext;
            r_init    <= w_initNext;
            r_grant   <= w_grantNext;
            r_timeout <= w_timeoutNext;
        end
    end

    assign cmd     = r_cmd;
    assign arg     = r_arg;
    assign crc     = r_crc;
    assign sta     = r_sta;
    assign sta40   = r_sta40;
    assign readit  = r_readit;
    assign init    = r_init;
    assign grant   = r_grant;
    assign busy    = (r_state != S_IDLE);
    assign timeout = r_timeout;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Directed bench for sd_cmd_arbiter: a 2-channel fixed-priority instance and a 4-channel round-robin instance.
module tb_sd_cmd_arbiter;

    logic clk;
    logic rst;

    logic [11:0] fReqCmd;
    logic [63:0] fReqArg;
    logic [13:0] fReqCrc;
    logic [1:0]  fReqSta, fReqSta40, fReqReadit, fReqInit;
    logic        fDone;
    logic [5:0]  fCmd;
    logic [31:0] fArg;
    logic [6:0]  fCrc;
    logic        fSta, fSta40, fReadit, fInit, fBusy, fTimeout;
    logic [1:0]  fGrant;

    logic [23:0]  rReqCmd;
    logic [127:0] rReqArg;
    logic [27:0]  rReqCrc;
    logic [3:0]   rReqSta, rReqSta40, rReqReadit, rReqInit;
    logic         rDone;
    logic [5:0]   rCmd;
    logic [31:0]  rArg;
    logic [6:0]   rCrc;
    logic         rSta, rSta40, rReadit, rInit, rBusy, rTimeout;
    logic [3:0]   rGrant;

    int nCompared;
    int nMismatched;

    // {grant, sta, sta40, busy, timeout, readit, init}
    logic [7:0]  fStat;
    logic [44:0] fFields;
    logic [52:0] fAll;
    logic [54:0] rAll;
    assign fStat   = {fGrant, fSta, fSta40, fBusy, fTimeout, fReadit, fInit};
    assign fFields = {fCmd, fArg, fCrc};
    assign fAll    = {fFields, fStat};
    assign rAll    = {rCmd, rArg, rCrc, rGrant, rSta, rSta40, rBusy, rTimeout, rReadit, rInit};

    sd_cmd_arbiter #(.NCH(2), .CMDW(6), .ARGW(32), .CRCW(7), .RR_MODE(0), .TO_CYC(8)) dutFixed (
        .clk(clk), .rst(rst),
        .req_cmd(fReqCmd), .req_arg(fReqArg), .req_crc(fReqCrc),
        .req_sta(fReqSta), .req_sta40(fReqSta40), .req_readit(fReqReadit), .req_init(fReqInit),
        .done(fDone),
        .cmd(fCmd), .arg(fArg), .crc(fCrc), .sta(fSta), .sta40(fSta40),
        .readit(fReadit), .init(fInit), .grant(fGrant), .busy(fBusy), .timeout(fTimeout)
    );

    sd_cmd_arbiter #(.NCH(4), .CMDW(6), .ARGW(32), .CRCW(7), .RR_MODE(1), .TO_CYC(8)) dutRr (
        .clk(clk), .rst(rst),
        .req_cmd(rReqCmd), .req_arg(rReqArg), .req_crc(rReqCrc),
        .req_sta(rReqSta), .req_sta40(rReqSta40), .req_readit(rReqReadit), .req_init(rReqInit),
        .done(rDone),
        .cmd(rCmd), .arg(rArg), .crc(rCrc), .sta(rSta), .sta40(rSta40),
        .readit(rReadit), .init(rInit), .grant(rGrant), .busy(rBusy), .timeout(rTimeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        fReqCmd = '0; fReqArg = '0; fReqCrc = '0;
        fReqSta = '0; fReqSta40 = '0; fReqReadit = '0; fReqInit = '0; fDone = 1'b0;
        rReqCmd = {6'd13, 6'd12, 6'd11, 6'd10};
        rReqArg = {32'h3333, 32'h2222, 32'h1111, 32'h0000};
        rReqCrc = '0;
        rReqSta = '0; rReqSta40 = '0; rReqReadit = '0; rReqInit = '0; rDone = 1'b0;
        repeat (3) tick();
        nCompared++;
        if (fAll !== '0) begin
            nMismatched++;
            $display("[TB] FAIL reset_fixed: got %h expected 0", fAll);
        end
        nCompared++;
        if (rAll !== '0) begin
            nMismatched++;
            $display("[TB] FAIL reset_rr: got %h expected 0", rAll);
        end
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            nCompared++;
            if ({fAll, rAll} !== '0) begin
                nMismatched++;
                $display("[TB] FAIL idle_quiet cycle %0d: got %h / %h expected 0", c, fAll, rAll);
            end
        end
    endtask

    task automatic test_single;
        fReqCmd = {6'd17, 6'd0};
        fReqArg = {32'h0000_0200, 32'h0};
        fReqCrc = {7'h2B, 7'h0};
        fReqReadit = 2'b10;
        fReqSta = 2'b10;
        tick();
        fReqSta = 2'b00;
        nCompared++;
        if (fStat !== 8'b0) begin
            nMismatched++;
            $display("[TB] FAIL single_latency: got %b expected 00000000", fStat);
        end
        tick();
        nCompared++;
        if (fStat !== 8'b10101010) begin
            nMismatched++;
            $display("[TB] FAIL single_issue_status: got %b expected 10101010", fStat);
        end
        nCompared++;
        if (fFields !== {6'd17, 32'h0000_0200, 7'h2B}) begin
            nMismatched++;
            $display("[TB] FAIL single_issue_fields: got %h expected %h", fFields, {6'd17, 32'h0000_0200, 7'h2B});
        end
        fReqCmd = '0; fReqArg = '0; fReqCrc = '0; fReqReadit = '0;
        for (int c = 3; c <= 10; c++) begin
            tick();
            nCompared++;
            if ({fFields, fStat} !== {6'd17, 32'h0000_0200, 7'h2B, 8'b10001010}) begin
                nMismatched++;
                $display("[TB] FAIL single_hold cycle %0d: got %h", c, {fFields, fStat});
            end
        end
        fDone = 1'b1;
        tick();
        fDone = 1'b0;
        nCompared++;
        if (fAll !== '0) begin
            nMismatched++;
            $display("[TB] FAIL single_release: got %h expected 0", fAll);
        end
    endtask

    task automatic test_collision;
        fReqCmd = {6'd17, 6'd0};
        fReqArg = {32'h0000_0200, 32'h0};
        fReqCrc = {7'h11, 7'h4A};
        fReqInit = 2'b01;
        fReqSta = 2'b11;
        fReqSta40 = 2'b01;
        tick();
        fReqSta = '0; fReqSta40 = '0;
        nCompared++;
        if (fStat !== 8'b0) begin
            nMismatched++;
            $display("[TB] FAIL coll_idle: got %b expected 00000000", fStat);
        end
        tick();
        nCompared++;
        if ({fFields, fStat} !== {6'd0, 32'h0, 7'h4A, 8'b01011001}) begin
            nMismatched++;
            $display("[TB] FAIL coll_first: got %h expected %h", {fFields, fStat}, {6'd0, 32'h0, 7'h4A, 8'b01011001});
        end
        tick();
        nCompared++;
        if (fStat !== 8'b01001001) begin
            nMismatched++;
            $display("[TB] FAIL coll_first_wait: got %b expected 01001001", fStat);
        end
        fReqInit = 2'b00;
        fDone = 1'b1;
        tick();
        fDone = 1'b0;
        nCompared++;
        if (fAll !== '0) begin
            nMismatched++;
            $display("[TB] FAIL coll_gap: got %h expected 0", fAll);
        end
        tick();
        nCompared++;
        if ({fFields, fStat} !== {6'd17, 32'h0000_0200, 7'h11, 8'b10101000}) begin
            nMismatched++;
            $display("[TB] FAIL coll_second: got %h expected %h", {fFields, fStat}, {6'd17, 32'h0000_0200, 7'h11, 8'b10101000});
        end
        fDone = 1'b1;
        tick();
        fDone = 1'b0;
        nCompared++;
        if (fStat !== 8'b10001000) begin
            nMismatched++;
            $display("[TB] FAIL done_in_issue_ignored: got %b expected 10001000", fStat);
        end
        fDone = 1'b1;
        tick();
        fDone = 1'b0;
        nCompared++;
        if (fAll !== '0) begin
            nMismatched++;
            $display("[TB] FAIL coll_release: got %h expected 0", fAll);
        end
    endtask

    task automatic test_timeout;
        fReqCmd = {6'd24, 6'd9};
        fReqArg = {32'hBEEF, 32'hCAFE};
        fReqCrc = {7'h05, 7'h06};
        fReqSta = 2'b01;
        tick();
        fReqSta = '0;
        tick();
        nCompared++;
        if (fStat !== 8'b01101000 || fCmd !== 6'd9) begin
            nMismatched++;
            $display("[TB] FAIL to_issue: got %b cmd %0d expected 01101000 cmd 9", fStat, fCmd);
        end
        tick();
        fReqSta = 2'b10;
        tick();
        fReqSta = '0;
        for (int c = 4; c <= 10; c++) begin
            nCompared++;
            if (fStat !== 8'b01001000) begin
                nMismatched++;
                $display("[TB] FAIL to_wait cycle %0d: got %b expected 01001000", c, fStat);
            end
            tick();
        end
        nCompared++;
        if (fAll !== {45'h0, 8'b00000100}) begin
            nMismatched++;
            $display("[TB] FAIL to_pulse: got %h expected timeout only", fAll);
        end
        tick();
        nCompared++;
        if (fStat !== 8'b10101000 || fCmd !== 6'd24) begin
            nMismatched++;
            $display("[TB] FAIL to_next_served: got %b cmd %0d expected 10101000 cmd 24", fStat, fCmd);
        end
        tick();
        fDone = 1'b1;
        tick();
        fDone = 1'b0;
        nCompared++;
        if (fAll !== '0) begin
            nMismatched++;
            $display("[TB] FAIL to_next_release: got %h expected 0", fAll);
        end
    endtask

    task automatic test_done_timeout_tie;
        fReqCmd = {6'd0, 6'd8};
        fReqSta40 = 2'b01;
        tick();
        fReqSta40 = '0;
        tick();
        nCompared++;
        if (fStat !== 8'b01011000) begin
            nMismatched++;
            $display("[TB] FAIL tie_issue: got %b expected 01011000", fStat);
        end
        repeat (8) tick();
        fDone = 1'b1;
        tick();
        fDone = 1'b0;
        nCompared++;
        if (fAll !== '0) begin
            nMismatched++;
            $display("[TB] FAIL tie_no_timeout: got %h expected 0", fAll);
        end
        tick();
        nCompared++;
        if (fAll !== '0) begin
            nMismatched++;
            $display("[TB] FAIL tie_quiet_after: got %h expected 0", fAll);
        end
    endtask

    task automatic test_back_to_back;
        fReqCmd = {6'd33, 6'd0};
        fReqSta = 2'b10;
        tick();
        fReqSta = '0;
        tick();
        tick();
        fReqSta40 = 2'b10;
        tick();
        fReqSta40 = '0;
        fDone = 1'b1;
        tick();
        fDone = 1'b0;
        nCompared++;
        if (fAll !== '0) begin
            nMismatched++;
            $display("[TB] FAIL b2b_gap: got %h expected 0", fAll);
        end
        tick();
        nCompared++;
        if (fStat !== 8'b10011000 || fCmd !== 6'd33) begin
            nMismatched++;
            $display("[TB] FAIL b2b_regrant: got %b cmd %0d expected 10011000 cmd 33", fStat, fCmd);
        end
        fDone = 1'b1;
        tick();
        tick();
        fDone = 1'b0;
        nCompared++;
        if (fAll !== '0) begin
            nMismatched++;
            $display("[TB] FAIL b2b_release: got %h expected 0", fAll);
        end
    endtask

    task automatic test_reset_mid;
        fReqCmd = {6'd2, 6'd1};
        fReqSta = 2'b01;
        tick();
        fReqSta = '0;
        tick();
        tick();
        fReqSta = 2'b10;
        tick();
        fReqSta = '0;
        nCompared++;
        if (fStat !== 8'b01001000) begin
            nMismatched++;
            $display("[TB] FAIL rstmid_wait: got %b expected 01001000", fStat);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        nCompared++;
        if (fAll !== '0) begin
            nMismatched++;
            $display("[TB] FAIL rstmid_cleared: got %h expected 0", fAll);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            nCompared++;
            if (fAll !== '0) begin
                nMismatched++;
                $display("[TB] FAIL rstmid_pending_lost cycle %0d: got %h expected 0", c, fAll);
            end
        end
    endtask

    task automatic test_round_robin;
        int waitCnt;
        logic [3:0] expGrant;
        rReqSta = 4'b1111;
        tick();
        rReqSta = '0;
        for (int t = 0; t < 12; t++) begin
            waitCnt = 0;
            while (rGrant === 4'b0 && waitCnt < 10) begin
                tick();
                waitCnt++;
            end
            expGrant = 4'b0001 << (t % 4);
            nCompared++;
            if (rGrant !== expGrant || rSta !== 1'b1) begin
                nMismatched++;
                $display("[TB] FAIL rr_order txn %0d: got grant %b sta %b expected grant %b sta 1", t, rGrant, rSta, expGrant);
            end
            nCompared++;
            if (rCmd !== 6'(10 + (t % 4))) begin
                nMismatched++;
                $display("[TB] FAIL rr_cmd txn %0d: got %0d expected %0d", t, rCmd, 10 + (t % 4));
            end
            rReqSta = expGrant;
            tick();
            rReqSta = '0;
            rDone = 1'b1;
            tick();
            rDone = 1'b0;
        end
    endtask

    initial begin
        nCompared = 0;
        nMismatched = 0;
        test_reset();
        test_single();
        test_collision();
        test_timeout();
        test_done_timeout_tie();
        test_back_to_back();
        test_reset_mid();
        test_round_robin();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/sd_cmd_arbiter.md
Name: sd_cmd_arbiter

Overview:
- N-channel command arbiter for the SPI SD command path. It is the parametrised successor of the two-source OR-combiner that sits between the command sources (mandisk, initizer, future DMA/streamer) and `prepare`.
- It captures start pulses from each channel and grants exactly one channel at a time, fixed-priority or round-robin.
- It holds the granted command/argument/mode fields stable until the manager reports completion, and releases the grant on timeout.
- This removes the silent field corruption that occurs when two sources OR their buses together.

Parameters:
- NCH, 2, number of requesting channels (2..8); channel 0 is highest priority in fixed mode.
- CMDW, 6, command index width.
- ARGW, 32, argument width.
- CRCW, 7, CRC field width.
- RR_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TO_CYC, 65535, clk cycles in WAIT before forced release; 0 disables timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset (sampled on rising clk; low = reset).
- req_cmd  in  NCH*CMDW  channel i command at [i*CMDW +: CMDW].
- req_arg  in  NCH*ARGW  channel i argument.
- req_crc  in  NCH*CRCW  channel i precomputed CRC.
- req_sta  in  NCH  per-channel one-cycle start pulse (normal command).
- req_sta40  in  NCH  per-channel one-cycle start pulse (CMD with 40-clock preamble).
- req_readit  in  NCH  per-channel read-data mode flag (level).
- req_init  in  NCH  per-channel init mode flag (level).
- done  in  1  completion pulse from manager (rdy).
- cmd  out  CMDW  granted command.
- arg  out  ARGW  granted argument.
- crc  out  CRCW  granted CRC.
- sta  out  1  one-cycle start to prepare.
- sta40  out  1  one-cycle start40 to prepare.
- readit  out  1  granted readit flag.
- init  out  1  granted init flag.
- grant  out  NCH  one-hot owner of the current transaction; 0 when idle.
- busy  out  1  high in ISSUE/WAIT.
- timeout  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (rst=0 at a rising edge): all outputs 0, pending bits 0, kind bits 0, state IDLE, RR pointer 0, timeout counter 0.
- Pending capture:
  - Each channel has a pending bit and a kind bit.
  - req_sta[i] | req_sta40[i] sets pending[i] at the next edge; kind[i] <= req_sta40[i].
  - If both pulses occur in the same cycle, sta40 wins.
  - A pulse on an already-pending channel overwrites kind only; it does not queue.
- Fields are sampled from the channel at grant time, not at pulse time. Sources must hold cmd/arg/crc/readit/init until their grant rises.
- States:
  - IDLE: if any pending bit is set, select a winner.
    - Fixed mode: lowest index pending.
    - RR mode: first pending index at or above the pointer, wrapping modulo NCH.
    - On the selection edge: latch the winner's cmd/arg/crc/readit/init into the outputs; set grant=onehot(winner); clear pending[winner]; assert sta or sta40 per kind[winner]; go to ISSUE.
  - ISSUE: lasts exactly 1 cycle, with sta/sta40 high during it. Then sta/sta40 drop to 0 and the state goes to WAIT with the counter cleared.
  - WAIT: outputs held stable; the counter increments each cycle.
    - On done=1: go to IDLE.
    - If TO_CYC≠0 and the counter reaches TO_CYC-1 without done: pulse timeout for 1 cycle and go to IDLE.
    - On either exit: cmd/arg/crc/readit/init/grant return to 0, and in RR mode the pointer becomes (winner+1) mod NCH.
- Latency: a request pulse in cycle 0 with the arbiter idle gives grant and sta high in cycle 2.
  - The earliest next issue after done in cycle d is sta high in cycle d+2; IDLE lasts at least 1 cycle, so back-to-back grants are always separated by one idle cycle with zero fields.
- Boundary conditions:
  - done in ISSUE or IDLE: ignored.
  - done and timeout in the same cycle: done wins and no timeout pulse is issued.
  - A request from the granted channel during ISSUE/WAIT: captured as a new pending; it does not extend the current grant.
  - All NCH channels requesting simultaneously in RR mode: each is served exactly once before any repeats.
  - rst low mid-transaction: immediate return to reset values on that edge; pending requests are lost.
  - Widths: the timeout counter is ceil(log2(TO_CYC+1)) bits, minimum 1. The pointer is ceil(log2(NCH)) bits, minimum 1.

Test Plan:
- Reset/idle: hold rst=0 for 3 cycles, release, no requests for 20 cycles -> all outputs 0 throughout, busy=0.
- Single request: NCH=2, ch1 cmd=6'd17, arg=32'h0000_0200, req_sta[1] pulse at cycle 0 -> cycle 2: sta=1, grant=2'b10, cmd=17, arg=0x200. Fields held until done at cycle 10; cycle 11: outputs 0.
- Collision, fixed mode (RR_MODE=0): ch0 (CMD0, sta40) and ch1 (CMD17, sta) pulse in the same cycle -> ch0 issued first with sta40=1; after done, ch1 issued with sta=1. Never both grants set, never ORed fields.
- Round-robin fairness (NCH=4, RR_MODE=1): all channels re-request immediately after each of their grants for 12 transactions -> grant order 0,1,2,3,0,1,2,3,0,1,2,3.
- Timeout (TO_CYC=8): grant ch0, never assert done -> timeout pulses exactly 8 cycles after WAIT entry, grant returns to 0, pending ch1 is then served.
- Reset mid-WAIT and done/timeout tie: assert rst=0 during WAIT -> all outputs 0 next cycle. Separately, with TO_CYC=8, assert done in the terminal count cycle -> no timeout pulse.
